// File: rtl/dp_pkg.sv
// Shared datapath definitions: ALU op encodings and default widths.
// Used by microcode_datapath and microcode_fsm.
package dp_pkg;

    localparam int DP_N = 16;
    localparam int DP_M = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_MOV = 3'b110,
        OP_INC = 3'b111
    } op_e;

endpackage

// File: rtl/microcode_datapath_if.sv
// Control word, data inputs and status returned between microcode_fsm (master)
// and microcode_datapath (slave).
interface microcode_datapath_if #(
    parameter int N = dp_pkg::DP_N,
    parameter int M = dp_pkg::DP_M
);

    logic [N-1:0] din;
    logic [N-1:0] offset;
    logic [M-1:0] waddr;
    logic [M-1:0] ra;
    logic [M-1:0] rb;
    logic [2:0]   op;
    logic         ie;
    logic         write;
    logic         reada;
    logic         readb;
    logic         en;
    logic         oe;
    logic         bypassa;
    logic         bypassb;
    logic         mov_sel;
    logic [N-1:0] dout;
    logic         o_flag;
    logic         z_flag;
    logic         n_flag;

    modport master (
        output din, offset, waddr, ra, rb, op, ie, write, reada, readb,
               en, oe, bypassa, bypassb, mov_sel,
        input  dout, o_flag, z_flag, n_flag
    );

    modport slave (
        input  din, offset, waddr, ra, rb, op, ie, write, reada, readb,
               en, oe, bypassa, bypassb, mov_sel,
        output dout, o_flag, z_flag, n_flag
    );

endinterface

// File: rtl/dp_alu.sv
// Combinational ALU: N-bit wrapping result plus signed-overflow indication.
module dp_alu
    import dp_pkg::*;
#(
    parameter int N = DP_N
) (
    input  logic signed [N-1:0] opa_i,
    input  logic signed [N-1:0] opb_i,
    input  op_e                 op_i,
    output logic signed [N-1:0] result_o,
    output logic                ovf_o
);

    always_comb begin
        result_o = '0;
        ovf_o    = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                result_o = opa_i + opb_i;
                ovf_o    = (opa_i[N-1] == opb_i[N-1]) && (result_o[N-1] != opa_i[N-1]);
            end
            OP_SUB: begin
                result_o = opa_i - opb_i;
                ovf_o    = (opa_i[N-1] != opb_i[N-1]) && (result_o[N-1] != opa_i[N-1]);
            end
            OP_AND: result_o = opa_i & opb_i;
            OP_OR:  result_o = opa_i | opb_i;
            OP_XOR: result_o = opa_i ^ opb_i;
            OP_NOT: result_o = ~opa_i;
            OP_MOV: result_o = opa_i;
            OP_INC: begin
                result_o = opa_i + N'(1);
                // The implicit +1 operand is positive, so only a positive opA can overflow.
                ovf_o    = !opa_i[N-1] && result_o[N-1];
            end
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/microcode_datapath.sv
// Execution datapath: register file, operand muxes, ALU, flags and output register.
// Optional build macro: DP_RF_FORWARD_EN (read-during-write forwarding).
module microcode_datapath
    import dp_pkg::*;
#(
    parameter int N = DP_N,
    parameter int M = DP_M
) (
    input  logic                 clk,
    input  logic                 rst,
    microcode_datapath_if.slave  dp
);

    localparam int NREG = 2 ** M;

    logic [N-1:0] rf_q [NREG];
    logic [N-1:0] rf_d [NREG];
    logic [N-1:0] dout_q, dout_d;
    logic         o_q, o_d;
    logic         z_q, z_d;
    logic         n_q, n_d;

    logic [N-1:0]        rd_a, rd_b;
    logic signed [N-1:0] opa, opb, result;
    logic                ovf;
    logic [N-1:0]        wdata;
    logic [N-1:0]        fwd_data;
    logic                fwd_ok;

    // Only din/offset writes are forwarded: forwarding an ALU-sourced write
    // would route the ALU output back into its own operands combinationally.
`ifdef DP_RF_FORWARD_EN
    assign fwd_ok = dp.write & (dp.ie | dp.mov_sel);
`else
    assign fwd_ok = 1'b0;
`endif
    assign fwd_data = dp.ie ? dp.din : dp.offset;

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (dp.reada) rd_a = (fwd_ok && dp.waddr == dp.ra) ? fwd_data : rf_q[dp.ra];
        if (dp.readb) rd_b = (fwd_ok && dp.waddr == dp.rb) ? fwd_data : rf_q[dp.rb];
    end

    assign opa = dp.bypassa ? dp.din    : rd_a;
    assign opb = dp.bypassb ? dp.offset : rd_b;

    dp_alu #(.N(N)) u_alu (
        .opa_i    (opa),
        .opb_i    (opb),
        .op_i     (op_e'(dp.op)),
        .result_o (result),
        .ovf_o    (ovf)
    );

    assign wdata = dp.ie ? dp.din : (dp.mov_sel ? dp.offset : result);

    always_comb begin
        rf_d = rf_q;
        if (dp.write) rf_d[dp.waddr] = wdata;
        dout_d = dp.oe ? result : dout_q;
        // Flags always track the ALU, independent of the write-data source.
        o_d = dp.en ? ovf             : o_q;
        z_d = dp.en ? (result == '0)  : z_q;
        n_d = dp.en ? result[N-1]     : n_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            dout_q <= '0;
            o_q    <= 1'b0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
        end else begin
            rf_q   <= rf_d;
            dout_q <= dout_d;
            o_q    <= o_d;
            z_q    <= z_d;
            n_q    <= n_d;
        end
    end

    assign dp.dout   = dout_q;
    assign dp.o_flag = o_q;
    assign dp.z_flag = z_q;
    assign dp.n_flag = n_q;

endmodule
